// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter
// ------------------
// N-port round-robin output arbiter for the NoC router. The holder keeps the
// grant while it requests, up to a per-packet limit that is loaded from the
// head flit's length field. When the holder releases, the grant passes to the
// next requesting port in round-robin order. When the arbiter is idle, the
// search starts either after the last granted port (RR_IDLE=1) or at port 0
// (RR_IDLE=0, fixed priority).
//
// Ports:
//   clk           - clock
//   rst           - synchronous, active-high reset
//   req           - per-port request
//   flit_id       - per-port flit type, port i at [i*FLIT_ID_W +: FLIT_ID_W]
//   length        - per-port timeout length, port i at [i*LEN_W +: LEN_W]
//   grant         - registered one-hot grant, all zeros when idle
//   grant_valid   - registered OR of grant
//   grant_idx     - registered binary index of the granted port, 0 when idle
//   timeout_pulse - one-cycle pulse on port i when it loses the grant by
//                   expiry while still requesting
module rr_timeout_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W     = 12,
  parameter int FLIT_ID_W = 3,
  parameter int HEAD_ID   = 1,
  parameter int RR_IDLE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0]    length,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
  output logic [NUM_PORTS-1:0]          timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  // One-hot decode of a port index.
  function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    to_onehot = NUM_PORTS'(1) << idx;
  endfunction

  // Registered state
  logic [NUM_PORTS-1:0] grant_r;
  logic                 grant_valid_r;
  logic [IDX_W-1:0]     grant_idx_r;
  logic [NUM_PORTS-1:0] pulse_r;
  logic [IDX_W-1:0]     last_r;
  logic [LEN_W-1:0]     limit_r [NUM_PORTS];
  logic [LEN_W-1:0]     count_r [NUM_PORTS];

  // Combinational next-state signals
  logic [NUM_PORTS-1:0] head_s;
  logic [NUM_PORTS-1:0] expired_s;
  logic [IDX_W-1:0]     start_s;
  logic [IDX_W-1:0]     pick_s;
  logic                 found_s;
  logic                 hold_s;
  logic                 new_grant_s;
  logic [NUM_PORTS-1:0] grant_nxt_s;
  logic [IDX_W-1:0]     idx_nxt_s;
  logic [NUM_PORTS-1:0] pulse_nxt_s;

  assign grant         = grant_r;
  assign grant_valid   = grant_valid_r;
  assign grant_idx     = grant_idx_r;
  assign timeout_pulse = pulse_r;

  // Per-port head-flit detection and timer expiry compare.
  always_comb begin
    head_s    = '0;
    expired_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_s[i]    = (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(HEAD_ID));
      // An unsigned >= also catches a limit that was reloaded below the running count.
      expired_s[i] = grant_r[i] && (count_r[i] >= limit_r[i]);
    end
  end

  // Rotating priority search: first requester after start_s.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    if (grant_valid_r) begin
      start_s = grant_idx_r;
    end else if (RR_IDLE != 0) begin
      start_s = last_r;
    end else begin
      // Starting "after" the last port makes port 0 the first candidate.
      start_s = IDX_W'(NUM_PORTS - 1);
    end
    // Walk from the farthest offset down so the nearest hit is written last.
    // Offset NUM_PORTS is the start port itself. It is a candidate only when
    // idle: a releasing holder never re-grants itself in the same cycle.
    for (int off = NUM_PORTS; off >= 1; off--) begin
      logic [IDX_W-1:0] cand;
      logic             hit;
      cand    = IDX_W'((int'(start_s) + off) % NUM_PORTS);
      hit     = req[cand] && ((off < NUM_PORTS) || !grant_valid_r);
      found_s = found_s | hit;
      pick_s  = hit ? cand : pick_s;
    end
  end

  // Next grant, index and timeout pulse.
  always_comb begin
    hold_s      = |(grant_r & req & ~expired_s);
    grant_nxt_s = '0;
    idx_nxt_s   = '0;
    new_grant_s = 1'b0;
    if (hold_s) begin
      grant_nxt_s = grant_r;
      idx_nxt_s   = grant_idx_r;
    end else if (found_s) begin
      grant_nxt_s = to_onehot(pick_s);
      idx_nxt_s   = pick_s;
      new_grant_s = 1'b1;
    end else begin
      grant_nxt_s = '0;
      idx_nxt_s   = '0;
    end
    // If the holder is still requesting and is not held, it expired.
    pulse_nxt_s = hold_s ? '0 : (grant_r & req & expired_s);
  end

  // Grant, pulse, last-granted and per-port timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      grant_idx_r   <= '0;
      pulse_r       <= '0;
      last_r        <= IDX_W'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        limit_r[i] <= '0;
        count_r[i] <= '0;
      end
    end else begin
      grant_r       <= grant_nxt_s;
      grant_valid_r <= |grant_nxt_s;
      grant_idx_r   <= idx_nxt_s;
      pulse_r       <= pulse_nxt_s;
      if (new_grant_s) begin
        last_r <= pick_s;
      end else begin
        last_r <= last_r;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (head_s[i]) begin
          limit_r[i] <= length[i*LEN_W +: LEN_W];
        end else begin
          limit_r[i] <= limit_r[i];
        end
        // The count runs only while the same port keeps the grant. A grant
        // that is new or re-issued starts again from 0.
        if (hold_s && grant_r[i]) begin
          count_r[i] <= count_r[i] + LEN_W'(1);
        end else begin
          count_r[i] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/rr_timeout_arbiter.md
# rr_timeout_arbiter

Parametrised N-port output arbiter for the NoC router. It succeeds the fixed 5-port L/N/E/W/S arbiter. Each input port holds its grant while requesting, up to a per-packet timeout loaded from the head flit's length field. On release, the grant passes round-robin to the next requesting port. New behaviour over the 5-port block:

- registered one-hot plus binary grant outputs;
- per-port timeout event pulses;
- selectable idle priority mode.

## Interface

Parameters:

- NUM_PORTS, 5: number of input ports; port 0 is Local, then N, E, W, S.
- LEN_W, 12: width of the length/timeout field and of each timer counter.
- FLIT_ID_W, 3: width of each flit_id field.
- HEAD_ID, 1: flit_id value that marks a head flit.
- RR_IDLE, 1: idle search mode. 1 starts from the port after the last granted port; 0 always starts from port 0 (fixed priority).

Ports:

- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- req, in, NUM_PORTS: per-port request.
- flit_id, in, NUM_PORTS*FLIT_ID_W: per-port flit type; port i occupies bits [i*FLIT_ID_W +: FLIT_ID_W].
- length, in, NUM_PORTS*LEN_W: per-port timeout length; port i occupies bits [i*LEN_W +: LEN_W].
- grant, out, NUM_PORTS: registered one-hot grant; all zeros when idle.
- grant_valid, out, 1: OR of grant.
- grant_idx, out, $clog2(NUM_PORTS): binary index of the granted port; 0 when idle.
- timeout_pulse, out, NUM_PORTS: one-cycle pulse on port i when it loses the grant by expiry while still requesting.

## Operation

Per-port timer i:

- limit[i] loads length[i] on every cycle where flit_id[i]==HEAD_ID, independent of grant state.
- count[i] increments while grant[i]==1, and is 0 otherwise.
- expired[i] = grant[i] && (count[i] >= limit[i]). The comparison is unsigned. Using >= covers a limit reloaded below the running count.
- count[i] never wraps: the grant drops at expiry, so the counter is cleared.

State is the granted port register (one-hot) plus last[i] (index of the most recently granted port). Next-grant logic:

- **Hold.** The holder h keeps the grant if req[h] && !expired[h].
- **Release.** Otherwise, search ports h+1 … h+NUM_PORTS-1 (mod NUM_PORTS) for the first with req=1.
  - The holder is excluded from this search. A lone expiring requester therefore goes idle for one cycle and is re-granted after that.
  - If no port is found, the arbiter goes idle.
- **Idle.** With RR_IDLE=1, search last+1 … last+NUM_PORTS (mod NUM_PORTS), which includes last. With RR_IDLE=0, search 0 … NUM_PORTS-1.
- last updates to the new index whenever a new grant is issued.
- **timeout_pulse[h]** is registered alongside the grant. It is 1 in the cycle after a release caused by expired[h] while req[h]==1. It is never asserted for a voluntary release (req dropped).
- **Simultaneous requests.** The first port in search order wins. Other requests wait with no starvation: each port is served within NUM_PORTS grants.
- **Reset values:** grant=0, grant_valid=0, grant_idx=0, timeout_pulse=0, all count=0, all limit=0, last=NUM_PORTS-1 (port 0 is first after reset in both modes).
- **Reset mid-grant** drops the grant in the cycle after rst is sampled and clears the timers. Pending limits are lost; a new head flit is required to reload them.

## Timing

- All outputs are registered.
- req/flit_id/length sampled at edge t affect grant at t+1.
- Grant duration with continuous request = limit+1 cycles. count goes 0..limit, and the grant drops on the edge after count reaches limit.
  - limit=0 gives a 1-cycle grant.
  - After reset with no head flit, limit=0, so grants last 1 cycle.
- A head flit on the first granted cycle updates limit; the new limit is used from the next cycle's compare.
- Handover between two requesting ports has no idle gap: the release cycle directly switches grant to the next port.
- Going idle → re-grant costs 1 cycle.
- Combinational path req→next grant: one rotate plus a priority encoder over NUM_PORTS.

## Test plan

- **Reset.** Reset, then req=5'b00001 with limit never loaded → grant=00001, grant_idx=0, then 1-cycle grant, 1 idle cycle, repeat. timeout_pulse[0] pulses each time.
- **Load and hold.** Port 2 gets a head flit with length=3, then req[2] held → grant=00100 for exactly 4 cycles. timeout_pulse[2]=1 on the next cycle; grant idle for 1 cycle, then re-granted.
- **Round robin.** All req=1, all limits=1 → grant order 0,1,2,3,4,0 with 2 cycles each and no idle gaps.
- **Voluntary release.** Port 3 granted (limit 10); req[3] drops after 2 cycles while req[1]=1 → grant moves to port 1 next cycle; timeout_pulse stays 0.
- **Idle priority mode.** Last grant on port 3; idle; then req=10011 → RR_IDLE=1 grants port 4, RR_IDLE=0 grants port 0.
- **Reset mid-operation.** rst asserted mid-grant on port 1 (count=5) → next cycle grant=0 and counts=0. A subsequent req[1] without a head flit gets a 1-cycle grant.
